// File: rtl/conv_stream_sequencer.sv
// -----------------------------------------------------------------------------
// conv_stream_sequencer
//
// Purpose:
//   Streams one convolution layer's operands from a word-addressed memory into
//   the convolution datapath. An accepted start first presents a config word
//   {53'h0, size, mode}. It then reads 9 weights followed by N*N pixels from
//   consecutive addresses starting at the latched base address, and forwards
//   each returned word. After the stream it waits for the datapath's done
//   indication and then pulses o_done.
//
// Optional feature:
//   CONV_SEQ_TIMEOUT_EN - when defined, a watchdog counts cycles in WAIT_DONE.
//   If TIMEOUT_CYCLES elapse without i_acc_done, the block pulses o_err and
//   returns to IDLE without o_done.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   i_start      one-cycle request to run a layer (honoured only in IDLE)
//   i_img_size   image side N, legal range 1..MAX_SIZE
//   i_mode       accelerator mode bits, echoed in the config word
//   i_base_addr  word address of weight 0
//   o_rd_en      memory read strobe
//   o_rd_addr    memory read address (holds while o_rd_en is low)
//   i_rd_data    read data, valid the cycle after o_rd_en
//   o_acc_data   word to the datapath (holds while o_acc_valid is low)
//   o_acc_valid  o_acc_data valid
//   i_acc_done   datapath finished the frame (honoured only in WAIT_DONE)
//   o_busy       high whenever not IDLE
//   o_done       one-cycle completion pulse
//   o_err        one-cycle error pulse (illegal size, or watchdog expiry)
// -----------------------------------------------------------------------------
module conv_stream_sequencer #(
   parameter int unsigned ADDR_W         = 18,
   parameter int unsigned MAX_SIZE       = 416,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [8:0]        i_img_size,
   input  logic [1:0]        i_mode,
   input  logic [ADDR_W-1:0] i_base_addr,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [63:0]       i_rd_data,
   output logic [63:0]       o_acc_data,
   output logic              o_acc_valid,
   input  logic              i_acc_done,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   // 9 + 511*511 = 261130 reads fits in 19 bits; 20 leaves headroom.
   localparam int unsigned CNT_W = 20;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDrain,
      StWaitDone
   } state_t;

   state_t              r_state;
   logic [8:0]          r_size;
   logic [1:0]          r_mode;
   logic [CNT_W-1:0]    r_last;      // index of the final read (8 + N*N)
   logic [CNT_W-1:0]    r_rd_cnt;    // index of the read issued this cycle
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_rd_pend;   // i_rd_data carries a requested word
   logic                r_cfg_pend;  // config word goes out next cycle
   logic [63:0]         r_acc_data;
   logic                r_acc_valid;
   logic                r_done;
   logic                r_err;

   logic [17:0]         w_sq;
   logic [CNT_W-1:0]    w_last;
   logic                w_size_ok;

   assign w_sq      = 18'(i_img_size) * 18'(i_img_size);
   assign w_last    = CNT_W'(w_sq) + CNT_W'(8);
   assign w_size_ok = (i_img_size != 9'd0) && (32'(i_img_size) <= MAX_SIZE);

`ifdef CONV_SEQ_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0]     r_to_cnt;
`else
   logic                w_unused_to;
   assign w_unused_to = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_size      <= '0;
         r_mode      <= '0;
         r_last      <= '0;
         r_rd_cnt    <= '0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_pend   <= 1'b0;
         r_cfg_pend  <= 1'b0;
         r_acc_data  <= '0;
         r_acc_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cfg_pend <= 1'b0;
         // Data returns one cycle after the strobe; a reset clears this so a
         // read in flight across reset is dropped.
         r_rd_pend  <= r_rd_en;

         // Datapath output: config word first, then each returned read word.
         // The config slot and the first read return never coincide.
         if (r_cfg_pend) begin
            r_acc_data  <= {53'h0, r_size, r_mode};
            r_acc_valid <= 1'b1;
         end else if (r_rd_pend) begin
            r_acc_data  <= i_rd_data;
            r_acc_valid <= 1'b1;
         end else begin
            r_acc_valid <= 1'b0;
         end

         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (w_size_ok) begin
                     r_size     <= i_img_size;
                     r_mode     <= i_mode;
                     r_last     <= w_last;
                     r_rd_cnt   <= '0;
                     r_rd_en    <= 1'b1;
                     r_rd_addr  <= i_base_addr;
                     r_cfg_pend <= 1'b1;
                     r_state    <= StStream;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end

            StStream: begin
               if (r_rd_cnt == r_last) begin
                  // Address stays on the final word while the strobe is low.
                  r_rd_en <= 1'b0;
                  r_state <= StDrain;
               end else begin
                  r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
                  r_rd_addr <= r_rd_addr + ADDR_W'(1);
               end
            end

            StDrain: begin
               // Last word is on o_acc_data this cycle and nothing is in flight.
               if (r_acc_valid && !r_rd_pend) begin
                  r_state <= StWaitDone;
`ifdef CONV_SEQ_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end

            StWaitDone: begin
               if (i_acc_done) begin
                  r_done  <= 1'b1;
                  r_state <= StIdle;
`ifdef CONV_SEQ_TIMEOUT_EN
               end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= StIdle;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
               end
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_rd_en     = r_rd_en;
   assign o_rd_addr   = r_rd_addr;
   assign o_acc_data  = r_acc_data;
   assign o_acc_valid = r_acc_valid;
   assign o_busy      = (r_state != StIdle);
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_stream_sequencer
//
// Purpose:
//   Self-checking bench for conv_stream_sequencer. A memory model answers reads
//   with an address-derived word. A reference model computes, for every cycle of
//   a layer run, the expected strobe, address, datapath word and status
//   outputs from the run's start cycle. Covers directed runs, illegal sizes,
//   ignored events, mid-stream reset, address wrap and randomized layers.
//   Optional: CONV_SEQ_TIMEOUT_EN selects the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_conv_stream_sequencer;

   localparam int unsigned AW = 18;
   localparam int unsigned TO = 100;

   logic          clk;
   logic          rst;
   logic          i_start;
   logic [8:0]    i_img_size;
   logic [1:0]    i_mode;
   logic [AW-1:0] i_base_addr;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic [63:0]   i_rd_data;
   logic [63:0]   o_acc_data;
   logic          o_acc_valid;
   logic          i_acc_done;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   int            n_checks;
   int            n_fail;
   logic [AW-1:0] exp_addr;
   logic [63:0]   exp_acc;

   conv_stream_sequencer #(
      .ADDR_W         (AW),
      .MAX_SIZE       (416),
      .TIMEOUT_CYCLES (TO)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_img_size  (i_img_size),
      .i_mode      (i_mode),
      .i_base_addr (i_base_addr),
      .o_rd_en     (o_rd_en),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (i_rd_data),
      .o_acc_data  (o_acc_data),
      .o_acc_valid (o_acc_valid),
      .i_acc_done  (i_acc_done),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
      return {14'h2A5, a, 14'h1C3, ~a};
   endfunction

   // Memory: requested word one cycle after the strobe, junk otherwise.
   always @(posedge clk) begin
      if (o_rd_en) i_rd_data <= mem_word(o_rd_addr);
      else         i_rd_data <= {$urandom, $urandom};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_rd_en"},  64'(o_rd_en),     64'd0);
      check({tag, "_valid"},  64'(o_acc_valid), 64'd0);
      check({tag, "_busy"},   64'(o_busy),      64'd0);
      check({tag, "_done"},   64'(o_done),      64'd0);
      check({tag, "_addr"},   64'(o_rd_addr),   64'(exp_addr));
      check({tag, "_data"},   o_acc_data,       exp_acc);
   endtask

   // Called at a negedge with the DUT idle. Start is driven this cycle, so the
   // DUT's start cycle T is the next one (loop index j = 0).
   // done_off < 0 withholds i_acc_done; rst_off >= 0 resets at T+rst_off.
   task automatic run_layer(input int n, input logic [1:0] mode, input logic [AW-1:0] base,
                            input int done_off, input int extra_start_off,
                            input int early_done_off, input int rst_off);
      int          last_rd, last_val, wait_entry, end_j;
      logic        done_exp, err_exp;
      logic [63:0] cfg;
      last_rd    = 8 + n * n;
      last_val   = 10 + n * n;
      wait_entry = 11 + n * n;
      cfg        = {53'h0, 9'(n), mode};
      check("pre_start_busy", 64'(o_busy), 64'd0);
      i_start     = 1'b1;
      i_img_size  = 9'(n);
      i_mode      = mode;
      i_base_addr = base;
      if (rst_off >= 0)       end_j = rst_off + 2;
      else if (done_off >= 0) end_j = done_off + 1;
      else                    end_j = wait_entry + int'(TO);
      for (int j = 0; j <= end_j; j++) begin
         @(negedge clk);
         i_start    = 1'b0;
         i_acc_done = 1'b0;
         rst        = 1'b0;
         if (rst_off >= 0 && j > rst_off) begin
            exp_addr = '0;
            exp_acc  = '0;
            check_quiet("post_rst");
            check("post_rst_err", 64'(o_err), 64'd0);
         end else begin
            if (j <= last_rd) exp_addr = base + AW'(j);
            if (j == 1) exp_acc = cfg;
            else if (j >= 2 && j <= last_val) exp_acc = mem_word(base + AW'(j - 2));
            done_exp = (done_off >= 0) && (j == done_off + 1);
            err_exp  = (done_off < 0) && (rst_off < 0) && (j == end_j);
            check("rd_en",  64'(o_rd_en),     64'(j <= last_rd));
            check("rd_addr", 64'(o_rd_addr),  64'(exp_addr));
            check("acc_valid", 64'(o_acc_valid), 64'(j >= 1 && j <= last_val));
            check("acc_data", o_acc_data,     exp_acc);
            check("busy",   64'(o_busy),      64'(!(done_exp || err_exp)));
            check("done",   64'(o_done),      64'(done_exp));
            check("err",    64'(o_err),       64'(err_exp));
         end
         if (j == extra_start_off) begin
            i_start     = 1'b1;
            i_img_size  = 9'($urandom_range(1, 20));
            i_mode      = 2'($urandom);
            i_base_addr = AW'($urandom);
         end
         if (j == early_done_off) i_acc_done = 1'b1;
         if (j == done_off)       i_acc_done = 1'b1;
         if (j == rst_off)        rst = 1'b1;
      end
      i_start    = 1'b0;
      i_acc_done = 1'b0;
   endtask

   // Called at a negedge with the DUT idle.
   task automatic illegal(input int n);
      i_start     = 1'b1;
      i_img_size  = 9'(n);
      i_mode      = 2'($urandom);
      i_base_addr = AW'($urandom);
      @(negedge clk);
      i_start = 1'b0;
      check("illegal_err", 64'(o_err), 64'd1);
      check_quiet("illegal");
      @(negedge clk);
      check("illegal_err_clr", 64'(o_err), 64'd0);
      check_quiet("illegal_after");
   endtask

   initial begin
      int n, ds, es, ed;
      n_checks    = 0;
      n_fail      = 0;
      exp_addr    = '0;
      exp_acc     = '0;
      rst         = 1'b1;
      i_start     = 1'b0;
      i_img_size  = '0;
      i_mode      = '0;
      i_base_addr = '0;
      i_acc_done  = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset_err", 64'(o_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_quiet("idle");

      // Directed run with a stray start at T+5 and a stray done at T+20.
      run_layer(6, 2'b11, 18'h00100, 60, 5, 20, -1);

      // Illegal sizes, the first back-to-back with the done cycle.
      illegal(0);
      illegal(417);
      illegal($urandom_range(418, 511));

      // Mid-stream reset, then a fresh run replaying from the config word.
      run_layer(6, 2'b01, AW'($urandom), 50, -1, -1, 15);
      run_layer(6, 2'b10, AW'($urandom), 47, -1, -1, -1);

      // Address wrap, smallest and largest legal sizes.
      run_layer(2, 2'b00, 18'h3FFF8, 15, -1, -1, -1);
      run_layer(1, 2'b11, 18'h3FFFF, 12, 3, 7, -1);
      run_layer(416, 2'b01, AW'($urandom), -1, -1, -1, 20);

      // Randomized layers, back-to-back.
      for (int r = 0; r < 12; r++) begin
         n  = $urandom_range(1, 9);
         ds = 11 + n * n + $urandom_range(0, 5);
         es = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10 + n * n) : -1;
         ed = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10 + n * n) : -1;
         run_layer(n, 2'($urandom), AW'($urandom), ds, es, ed, -1);
      end

`ifdef CONV_SEQ_TIMEOUT_EN
      // Withheld done: watchdog error, no done.
      run_layer(3, 2'b10, AW'($urandom), -1, -1, -1, -1);
      @(negedge clk);
      check("post_timeout_err", 64'(o_err), 64'd0);
      check_quiet("post_timeout");
`else
      // Long wait: still busy well beyond any watchdog horizon.
      run_layer(3, 2'b10, AW'($urandom), 20 + 200, -1, -1, -1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

endmodule
